noise_injector: RTL and testbench
=================================

# noise_injector

Receive-side channel-impairment stage that merges the sampled channel signal with the noise stream from the noise generator. It sits directly downstream of the noise generator and upstream of the equalizer/slicer. The noise source has no backpressure, so noise samples are buffered in a small FIFO. Each accepted signal sample is paired with exactly one buffered noise sample, scaled, added with saturation, and presented on a valid/ready output register.

## Interface
- DATA_W, 8: width of signal, noise and output samples (two's complement)
- FIFO_DEPTH, 8: noise FIFO entries; power of two, minimum 2
- GAIN_SHIFT, 0: noise left-shift (gain 2^GAIN_SHIFT); range 0..3

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- en  in  1  global enable; low freezes all state
- noise_in  in  DATA_W  signed noise sample from the noise generator
- noise_in_valid  in  1  noise_in valid this cycle
- signal_in  in  DATA_W  signed channel sample
- signal_in_valid  in  1  signal_in valid
- signal_in_ready  out  1  block accepts signal_in this cycle (combinational)
- data_out  out  DATA_W  signed noisy sample
- data_out_valid  out  1  data_out valid
- data_out_ready  in  1  downstream accepts data_out
- fifo_level  out  $clog2(FIFO_DEPTH)+1  noise entries currently stored
- noise_drop_cnt  out  16  noise samples dropped on full FIFO; saturates at 16'hFFFF
- sat_cnt  out  16  outputs that were clipped; saturates at 16'hFFFF

## Operation
- Reset (async assert, sync release): data_out=0, data_out_valid=0, fifo_level=0, both counters=0, FIFO pointers=0. Reset mid-operation discards all buffered noise and any pending output.
- en=0: no push, no pop, no output update, no counter update. data_out and data_out_valid hold. signal_in_ready=0.
- Noise push: occurs when en && noise_in_valid && (fifo_level<FIFO_DEPTH || pop this cycle).
  - When en && noise_in_valid && full && no pop, the sample is dropped and noise_drop_cnt is incremented.
  - Pointers wrap modulo FIFO_DEPTH.
- signal_in_ready = en && fifo_level!=0 && (!data_out_valid || data_out_ready).
- There is no bypass. A noise sample written in cycle N is poppable from cycle N+1 only.
- Fire = signal_in_valid && signal_in_ready. On fire:
  - Pop the FIFO head n (oldest first).
  - Compute s = signal_in + (n <<< GAIN_SHIFT), sign-extended to DATA_W+GAIN_SHIFT+2 bits.
  - Clip s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If clipping occurs, increment sat_cnt.
  - Register the result to data_out and set data_out_valid=1.
- Output handshake (en=1, no fire): if data_out_valid && data_out_ready, clear data_out_valid. data_out holds its value.
- Output is stable while data_out_valid && !data_out_ready. Fire and drain in the same cycle replace data_out with the new value and keep data_out_valid=1.
- Simultaneous push and pop leaves fifo_level unchanged. This holds when the FIFO is full, so no drop occurs.
- Counters saturate and do not wrap.

## Timing
- Latency: signal accepted in cycle N appears on data_out with data_out_valid=1 after edge N+1 (1 cycle).
- Throughput: 1 sample/cycle when noise arrives at ≥1/cycle and data_out_ready stays high.
- fifo_level, noise_drop_cnt and sat_cnt update at the same edge as the push, drop or fire that changes them.
- signal_in_ready depends combinationally on data_out_ready. There is no other combinational input-to-output path.

## Test plan
- Reset and idle: hold rstn=0, then release with en=0 and noise_in_valid=1. All outputs stay 0 and fifo_level stays 0.
- Basic pairing, GAIN_SHIFT=0, data_out_ready=1:
  - Push noise {1, -1, 0}, then send signal {10, 20, -5}.
  - data_out = {11, 19, -5}, each 1 cycle after its accept.
  - fifo_level returns to 0.
- Saturation, GAIN_SHIFT=2:
  - noise 1 + signal 126 → 127, sat_cnt=1.
  - noise -1 + signal -126 → -128, sat_cnt=2.
  - noise 1 + signal 100 → 104, sat_cnt unchanged.
- Full and drop, FIFO_DEPTH=8, no signal:
  - Push 10 noise samples: fifo_level=8, noise_drop_cnt=2.
  - Then push and fire in the same cycle: fifo_level stays 8, noise_drop_cnt stays 2.
- Backpressure: with data_out_ready=0 after one output:
  - signal_in_ready=0, and data_out plus data_out_valid are held for 5 cycles.
  - Raising data_out_ready drains the output. A fire in that same cycle outputs the next sum with data_out_valid continuous.
- Empty and reset mid-stream:
  - With the FIFO empty, signal_in_valid=1 gives signal_in_ready=0.
  - Noise written at cycle N gives signal_in_ready=1 at N+1.
  - Asserting rstn low with 3 noise entries and a pending output clears fifo_level and data_out_valid immediately.

Source files
------------

// File: rtl/noise_injector_if.sv
// noise_injector_if
// Groups the streaming signals of the noise injector into one bundle.
//   noise_in / noise_in_valid     : noise generator stream (no backpressure)
//   signal_in / signal_in_valid   : channel sample stream, paired with
//   signal_in_ready                 signal_in_ready from the injector
//   data_out / data_out_valid     : noisy sample stream, paired with
//   data_out_ready                  data_out_ready from downstream
// Modports:
//   slave  : the injector side
//   master : the environment side (noise source, channel, downstream)
interface noise_injector_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] noise_in;
    logic              noise_in_valid;
    logic [DATA_W-1:0] signal_in;
    logic              signal_in_valid;
    logic              signal_in_ready;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;

    modport slave (
        input  noise_in,
        input  noise_in_valid,
        input  signal_in,
        input  signal_in_valid,
        output signal_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport master (
        output noise_in,
        output noise_in_valid,
        output signal_in,
        output signal_in_valid,
        input  signal_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/noise_injector.sv
// noise_injector
// Receive-side impairment stage: buffers noise samples in a small FIFO and
// adds one scaled noise sample (gain 2^GAIN_SHIFT) to every accepted channel
// sample, clipping the result to the DATA_W signed range.
// Ports:
//   clk            : system clock, rising edge
//   rstn           : asynchronous active-low reset
//   en             : global enable, low freezes all state
//   bus            : noise_injector_if.slave (noise, signal and output streams)
//   fifo_level     : number of buffered noise samples
//   noise_drop_cnt : noise samples lost to a full FIFO (saturating)
//   sat_cnt        : outputs that were clipped (saturating)
module noise_injector #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    noise_injector_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   noise_drop_cnt,
    output logic [15:0]                   sat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = DATA_W + GAIN_SHIFT + 2;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [15:0]       drop_cnt;
    logic [15:0]       clip_cnt;

    logic              full;
    logic              in_ready;
    logic              fire;
    logic              push;
    logic              drop;
    logic [SW-1:0]     sig_ext;
    logic [SW-1:0]     noise_ext;
    logic [SW-1:0]     sum;
    logic              overflow;
    logic [DATA_W-1:0] clipped;

    assign full     = (level == DEPTH_L);
    assign in_ready = en && (level != '0) && (!out_valid || bus.data_out_ready);
    assign fire     = bus.signal_in_valid && in_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = en && bus.noise_in_valid && (!full || fire);
    assign drop     = en && bus.noise_in_valid && full && !fire;

    // Sign-extend both operands wide enough that the scaled sum never wraps.
    assign sig_ext   = {{(SW-DATA_W){bus.signal_in[DATA_W-1]}}, bus.signal_in};
    assign noise_ext = {{(SW-DATA_W){mem[rd_ptr][DATA_W-1]}}, mem[rd_ptr]} << GAIN_SHIFT;
    assign sum       = sig_ext + noise_ext;

    // The sum fits in DATA_W bits only if all bits above the result's sign
    // bit are copies of it.
    assign overflow = !((&sum[SW-1:DATA_W-1]) || !(|sum[SW-1:DATA_W-1]));
    assign clipped  = overflow ? (sum[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                            : {1'b0, {(DATA_W-1){1'b1}}})
                               : sum[DATA_W-1:0];

    // Noise storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.noise_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            drop_cnt  <= '0;
            clip_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !fire) begin
                level <= level + LW'(1);
            end else if (fire && !push) begin
                level <= level - LW'(1);
            end
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (fire) begin
                out_data  <= clipped;
                out_valid <= 1'b1;
                if (overflow && clip_cnt != 16'hFFFF) begin
                    clip_cnt <= clip_cnt + 16'd1;
                end
            end else if (en && out_valid && bus.data_out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.signal_in_ready = in_ready;
    assign bus.data_out        = out_data;
    assign bus.data_out_valid  = out_valid;
    assign fifo_level          = level;
    assign noise_drop_cnt      = drop_cnt;
    assign sat_cnt             = clip_cnt;

endmodule

// File: tb/tb_noise_injector.sv
// tb_noise_injector
// Drives the noise injector with directed and randomized streams. A
// queue-based reference model predicts ready, FIFO level and counters per
// cycle and pushes every expected output sample into a scoreboard queue; an
// independent monitor compares the presented output against that queue.
module tb_noise_injector;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int GS    = 2;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [3:0]  fifo_level;
    logic [15:0] noise_drop_cnt;
    logic [15:0] sat_cnt;

    noise_injector_if #(.DATA_W(DW)) bus ();

    noise_injector #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .GAIN_SHIFT (GS)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .bus            (bus),
        .fifo_level     (fifo_level),
        .noise_drop_cnt (noise_drop_cnt),
        .sat_cnt        (sat_cnt)
    );

    int nq[$];
    int exp_q[$];
    bit dv_m;
    int drop_m;
    int sat_m;
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input bit e, input bit nv, input int n,
                                 input bit sv, input int s, input bit ordy);
        bit rdy_m;
        bit fire_m;
        int head;
        int res;
        en                  = e;
        bus.noise_in_valid  = nv;
        bus.noise_in        = n[DW-1:0];
        bus.signal_in_valid = sv;
        bus.signal_in       = s[DW-1:0];
        bus.data_out_ready  = ordy;
        #1;
        rdy_m  = e && (nq.size() != 0) && (!dv_m || ordy);
        fire_m = sv && rdy_m;
        checkOutput("signal_in_ready", int'(bus.signal_in_ready), int'(rdy_m));
        @(posedge clk);
        if (e) begin
            if (fire_m) begin
                head = nq.pop_front();
                res  = s + head * (1 << GS);
                if (res > 127) begin
                    res = 127;
                    if (sat_m < 65535) sat_m++;
                end else if (res < -128) begin
                    res = -128;
                    if (sat_m < 65535) sat_m++;
                end
                exp_q.push_back(res);
                dv_m = 1'b1;
            end else if (dv_m && ordy) begin
                dv_m = 1'b0;
            end
            if (nv) begin
                if (nq.size() < DEPTH) nq.push_back(n);
                else if (drop_m < 65535) drop_m++;
            end
        end
        #1;
        checkOutput("fifo_level", int'(fifo_level), nq.size());
        checkOutput("noise_drop_cnt", int'(noise_drop_cnt), drop_m);
        checkOutput("sat_cnt", int'(sat_cnt), sat_m);
        checkOutput("data_out_valid", int'(bus.data_out_valid), int'(dv_m));
    endtask

    task automatic doReset();
        rstn                = 1'b0;
        en                  = 1'b0;
        bus.noise_in_valid  = 1'b0;
        bus.signal_in_valid = 1'b0;
        bus.data_out_ready  = 1'b0;
        nq.delete();
        exp_q.delete();
        dv_m   = 1'b0;
        drop_m = 0;
        sat_m  = 0;
        #1;
        checkOutput("reset_fifo_level", int'(fifo_level), 0);
        checkOutput("reset_data_out_valid", int'(bus.data_out_valid), 0);
        checkOutput("reset_data_out", int'($signed(bus.data_out)), 0);
        checkOutput("reset_drop", int'(noise_drop_cnt), 0);
        checkOutput("reset_sat", int'(sat_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Scoreboard monitor: output must match the oldest expected sample while
    // valid, and is retired only when a transfer happens at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                checkOutput("out_valid_vs_queue", int'(bus.data_out_valid), int'(exp_q.size() != 0));
                if (bus.data_out_valid && exp_q.size() != 0) begin
                    checkOutput("data_out", int'($signed(bus.data_out)), exp_q[0]);
                    if (en && bus.data_out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn                = 1'b0;
        en                  = 1'b0;
        bus.noise_in        = '0;
        bus.noise_in_valid  = 1'b0;
        bus.signal_in       = '0;
        bus.signal_in_valid = 1'b0;
        bus.data_out_ready  = 1'b0;
        checks = 0;
        errors = 0;
        @(posedge clk);
        #1;
        doReset();

        // Disabled block ignores offered noise.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 5, 1, 3, 1);
        checkOutput("idle_data_out", int'($signed(bus.data_out)), 0);

        // Basic pairing.
        applyStimulus(1, 1, 1, 0, 0, 1);
        applyStimulus(1, 1, -1, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 10, 1);
        applyStimulus(1, 0, 0, 1, 20, 1);
        applyStimulus(1, 0, 0, 1, -5, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);

        // Saturation both ways, then an in-range sum.
        applyStimulus(1, 1, 1, 0, 0, 1);
        applyStimulus(1, 1, -1, 0, 0, 1);
        applyStimulus(1, 1, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 126, 1);
        applyStimulus(1, 0, 0, 1, -126, 1);
        applyStimulus(1, 0, 0, 1, 100, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);

        // Overfill then push and pop together at full.
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, i - 5, 0, 0, 1);
        applyStimulus(1, 1, 7, 1, 3, 1);
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 1, i * 11 - 40, 1);

        // Empty FIFO blocks the signal; new noise is poppable next cycle.
        applyStimulus(1, 0, 0, 1, 9, 1);
        applyStimulus(1, 1, 2, 1, 9, 1);
        applyStimulus(1, 0, 0, 1, 9, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);

        // Backpressure: held output, then drain and fire together.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, i + 3, 0, 0, 1);
        applyStimulus(1, 0, 0, 1, 30, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 40, 0);
        applyStimulus(1, 0, 0, 1, 50, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 9) < 7),
                          int'($urandom_range(0, 255)) - 128,
                          ($urandom_range(0, 9) < 6),
                          int'($urandom_range(0, 255)) - 128,
                          ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1);

        // Reset with buffered noise and a pending output.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, i, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 17, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
